decode_operand_stage: RTL and testbench

//  RV32I decode/operand stage between fetch and execute.
//  - Decodes the incoming instruction and drives rs1/rs2 to the register bank.
//  - Bank read data is registered (valid one cycle later); bank writes land on negedge.
//  - Merges bank data with EX/MEM/WB forwarding and presents a registered ID/EX bundle.
//  - Detects load-use hazards (stalls fetch) and honours pipeline flush.

---
 rtl/riscx_pkg.sv | 42 ++++
 rtl/imm_gen.sv | 28 ++
 rtl/decode_operand_stage.sv | 115 +++++++++++
 tb/tb_decode_operand_stage.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/riscx_pkg.sv
// Shared RV32I opcode constants, immediate formats and opcode property helpers
// used by the decode/operand stage.
package riscx_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {IMM_R, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_t;

  function automatic imm_t imm_type(input logic [6:0] opc);
    case (opc)
      OP_IMM, LOAD, JALR: return IMM_I;
      STORE:              return IMM_S;
      BRANCH:             return IMM_B;
      LUI, AUIPC:         return IMM_U;
      JAL:                return IMM_J;
      default:            return IMM_R;
    endcase
  endfunction

  function automatic logic uses_rs1(input logic [6:0] opc);
    return (opc == OP) || (opc == OP_IMM) || (opc == LOAD) || (opc == STORE) ||
           (opc == BRANCH) || (opc == JALR);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opc);
    return (opc == OP) || (opc == STORE) || (opc == BRANCH);
  endfunction

  function automatic logic writes_rd(input logic [6:0] opc);
    return (opc == OP) || (opc == OP_IMM) || (opc == LOAD) || (opc == JAL) ||
           (opc == JALR) || (opc == LUI) || (opc == AUIPC);
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate extractor: builds the 32-bit signed immediate
// for the instruction's format and sign-extends it to XLEN.
module imm_gen
  import riscx_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]            instr,
  output logic signed [XLEN-1:0] imm
);

  logic signed [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (imm_type(instr[6:0]))
      IMM_I: imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U: imm32 = {instr[31:12], 12'b0};
      IMM_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = XLEN'(imm32);

endmodule

// File: rtl/decode_operand_stage.sv
// RV32I decode/operand stage: decodes the fetched instruction into a registered
// ID/EX bundle, merges bank data with EX/MEM/WB forwarding, stalls on load-use.
module decode_operand_stage
  import riscx_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              REG_AW   = 5,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [31:0]       in_instr,
  input  logic [XLEN-1:0]   in_pc,
  output logic              in_ready,
  output logic [REG_AW-1:0] rf_rs1,
  output logic [REG_AW-1:0] rf_rs2,
  input  logic [XLEN-1:0]   rf_data1,
  input  logic [XLEN-1:0]   rf_data2,
  input  logic              fwd_ex_valid,
  input  logic [REG_AW-1:0] fwd_ex_rd,
  input  logic [XLEN-1:0]   fwd_ex_data,
  input  logic              fwd_mem_valid,
  input  logic [REG_AW-1:0] fwd_mem_rd,
  input  logic [XLEN-1:0]   fwd_mem_data,
  input  logic              fwd_wb_valid,
  input  logic [REG_AW-1:0] fwd_wb_rd,
  input  logic [XLEN-1:0]   fwd_wb_data,
  input  logic              flush,
  output logic              out_valid,
  output logic [XLEN-1:0]   out_pc,
  output logic [6:0]        out_opcode,
  output logic [2:0]        out_funct3,
  output logic              out_funct7b5,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_reg_write,
  output logic              out_is_load,
  output logic [XLEN-1:0]   out_imm,
  output logic [XLEN-1:0]   out_op1,
  output logic [XLEN-1:0]   out_op2
);

  logic [6:0]             opc_p0;
  logic [REG_AW-1:0]      rs1_p0, rs2_p0, rd_p0;
  logic signed [XLEN-1:0] imm_p0;
  logic                   hz_p0, fire_p0, load_p0;
  logic [REG_AW-1:0]      rs1_p1, rs2_p1;

  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic [XLEN-1:0]   bank
  );
    if (rs == '0)                                    return '0;
    else if (fwd_ex_valid  && (fwd_ex_rd  == rs))    return fwd_ex_data;
    else if (fwd_mem_valid && (fwd_mem_rd == rs))    return fwd_mem_data;
    else if (fwd_wb_valid  && (fwd_wb_rd  == rs))    return fwd_wb_data;
    else                                             return bank;
  endfunction

  assign opc_p0 = in_instr[6:0];
  assign rd_p0  = REG_AW'(in_instr[11:7]);
  // Unused sources are forced to x0 so they neither trip the hazard nor forward.
  assign rs1_p0 = uses_rs1(opc_p0) ? REG_AW'(in_instr[19:15]) : '0;
  assign rs2_p0 = uses_rs2(opc_p0) ? REG_AW'(in_instr[24:20]) : '0;
  assign rf_rs1 = rs1_p0;
  assign rf_rs2 = rs2_p0;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (in_instr),
    .imm   (imm_p0)
  );

  assign hz_p0 = out_valid && out_is_load && (out_rd != '0) &&
                 ((rs1_p0 == out_rd) || (rs2_p0 == out_rd));

  // Flush drains wrong-path fetch, so it opens the stage even over a hazard.
  assign in_ready = reset_n && (flush || !hz_p0);
  assign fire_p0  = in_valid && in_ready;
  assign load_p0  = fire_p0 && !flush;

  // ---- ID/EX register boundary ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid     <= 1'b0;
      out_pc        <= RESET_PC;
      out_opcode    <= '0;
      out_funct3    <= '0;
      out_funct7b5  <= 1'b0;
      out_rd        <= '0;
      out_reg_write <= 1'b0;
      out_is_load   <= 1'b0;
      out_imm       <= '0;
      rs1_p1        <= '0;
      rs2_p1        <= '0;
    end else begin
      out_valid <= load_p0;
      if (load_p0) begin
        out_pc        <= in_pc;
        out_opcode    <= opc_p0;
        out_funct3    <= in_instr[14:12];
        out_funct7b5  <= in_instr[30];
        out_rd        <= rd_p0;
        out_reg_write <= writes_rd(opc_p0) && (rd_p0 != '0);
        out_is_load   <= (opc_p0 == LOAD);
        out_imm       <= imm_p0;
        rs1_p1        <= rs1_p0;
        rs2_p1        <= rs2_p0;
      end
    end
  end

  assign out_op1 = fwd_sel(rs1_p1, rf_data1);
  assign out_op2 = fwd_sel(rs2_p1, rf_data2);

endmodule

// File: tb/tb_decode_operand_stage.sv
// Directed bench for decode_operand_stage: reset, decode, forwarding priority,
// load-use stall, flush over stall and immediate formats.
module tb_decode_operand_stage;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] in_instr, in_pc;
  logic        in_ready;
  logic [4:0]  rf_rs1, rf_rs2;
  logic [31:0] rf_data1, rf_data2;
  logic        fwd_ex_valid, fwd_mem_valid, fwd_wb_valid;
  logic [4:0]  fwd_ex_rd, fwd_mem_rd, fwd_wb_rd;
  logic [31:0] fwd_ex_data, fwd_mem_data, fwd_wb_data;
  logic        flush;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic        out_funct7b5;
  logic [4:0]  out_rd;
  logic        out_reg_write, out_is_load;
  logic [31:0] out_imm, out_op1, out_op2;

  int n_assert = 0;
  int n_fail   = 0;

  decode_operand_stage dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_ready(in_ready),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .fwd_ex_valid(fwd_ex_valid), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
    .fwd_mem_valid(fwd_mem_valid), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
    .fwd_wb_valid(fwd_wb_valid), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_pc(out_pc), .out_opcode(out_opcode),
    .out_funct3(out_funct3), .out_funct7b5(out_funct7b5), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_is_load(out_is_load), .out_imm(out_imm),
    .out_op1(out_op1), .out_op2(out_op2)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_fwd();
    fwd_ex_valid = 0;  fwd_ex_rd = 0;  fwd_ex_data = 0;
    fwd_mem_valid = 0; fwd_mem_rd = 0; fwd_mem_data = 0;
    fwd_wb_valid = 0;  fwd_wb_rd = 0;  fwd_wb_data = 0;
  endtask

  initial begin
    reset_n = 0; in_valid = 0; in_instr = 0; in_pc = 0; flush = 0;
    rf_data1 = 0; rf_data2 = 0;
    clear_fwd();
    repeat (2) tick();
    reset_n = 1;

    // Get a valid bundle in flight, then reset asynchronously mid-cycle
    in_valid = 1; in_instr = 32'h0050_0093; in_pc = 32'h100;
    tick();
    check("pre_reset_valid", {31'b0, out_valid}, 32'd1);
    #2 reset_n = 0;
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_rd", {27'b0, out_rd}, 32'd0);
    tick();
    reset_n = 1;
    #1;
    check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    // addi x1,x0,5
    rf_data1 = 32'h1234;
    tick();
    check("addi_valid", {31'b0, out_valid}, 32'd1);
    check("addi_rd", {27'b0, out_rd}, 32'd1);
    check("addi_imm", out_imm, 32'd5);
    check("addi_op1_x0", out_op1, 32'd0);
    check("addi_reg_write", {31'b0, out_reg_write}, 32'd1);
    check("addi_pc", out_pc, 32'h100);
    check("addi_opcode", {25'b0, out_opcode}, 32'h13);

    // add x3,x1,x1 with EX forward of x1
    in_instr = 32'h0010_81B3; in_pc = 32'h104;
    tick();
    rf_data1 = 0; rf_data2 = 0;
    fwd_ex_valid = 1; fwd_ex_rd = 1; fwd_ex_data = 32'd7;
    #1;
    check("ex_fwd_op1", out_op1, 32'd7);
    check("ex_fwd_op2", out_op2, 32'd7);
    check("add_rd", {27'b0, out_rd}, 32'd3);
    check("add_imm_r", out_imm, 32'd0);
    clear_fwd();

    // add x4,x2,x0: forwarding priority EX > MEM > WB > bank
    in_instr = 32'h0001_0233;
    tick();
    rf_data1 = 32'hDDDD_DDDD; rf_data2 = 32'h9999_9999;
    fwd_ex_valid = 1;  fwd_ex_rd = 2;  fwd_ex_data = 32'hAAAA_AAAA;
    fwd_mem_valid = 1; fwd_mem_rd = 2; fwd_mem_data = 32'hBBBB_BBBB;
    fwd_wb_valid = 1;  fwd_wb_rd = 2;  fwd_wb_data = 32'hCCCC_CCCC;
    #1;
    check("prio_ex", out_op1, 32'hAAAA_AAAA);
    check("prio_op2_x0", out_op2, 32'h0);
    fwd_ex_valid = 0; #1;
    check("prio_mem", out_op1, 32'hBBBB_BBBB);
    fwd_mem_valid = 0; #1;
    check("prio_wb", out_op1, 32'hCCCC_CCCC);
    fwd_wb_valid = 0; #1;
    check("prio_bank", out_op1, 32'hDDDD_DDDD);
    clear_fwd();

    // add x4,x0,x0 with a forward claiming rd=0
    in_instr = 32'h0000_0233;
    tick();
    rf_data1 = 32'h55;
    fwd_ex_valid = 1; fwd_ex_rd = 0; fwd_ex_data = 32'hFFFF_FFFF;
    #1;
    check("x0_read", out_op1, 32'h0);
    clear_fwd();
    rf_data1 = 0;

    // Load-use: lw x5,0(x2) then add x6,x5,x0
    in_instr = 32'h0001_2283;
    tick();
    check("lw_is_load", {31'b0, out_is_load}, 32'd1);
    check("lw_rd", {27'b0, out_rd}, 32'd5);
    in_instr = 32'h0010_0393; #1;
    check("no_hz_unused_src", {31'b0, in_ready}, 32'd1);
    in_instr = 32'h0002_8333; #1;
    check("hz_in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    check("hz_bubble", {31'b0, out_valid}, 32'd0);
    check("hz_one_cycle", {31'b0, in_ready}, 32'd1);
    tick();
    fwd_mem_valid = 1; fwd_mem_rd = 5; fwd_mem_data = 32'hDEAD_BEEF;
    #1;
    check("hz_issue_valid", {31'b0, out_valid}, 32'd1);
    check("hz_issue_rd", {27'b0, out_rd}, 32'd6);
    check("hz_mem_fwd", out_op1, 32'hDEAD_BEEF);
    clear_fwd();

    // Flush while a load-use hazard is pending
    in_instr = 32'h0001_2283;
    tick();
    in_instr = 32'h0002_8333; flush = 1; #1;
    check("flush_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    check("flush_kill", {31'b0, out_valid}, 32'd0);
    flush = 0; in_valid = 0;
    tick();
    check("flush_no_replay", {31'b0, out_valid}, 32'd0);

    // Immediate formats
    in_valid = 1; in_instr = 32'hFE00_0EE3;
    tick();
    check("beq_imm", out_imm, 32'hFFFF_FFFC);
    check("beq_no_write", {31'b0, out_reg_write}, 32'd0);
    in_instr = 32'h1234_5037;
    tick();
    check("lui_imm", out_imm, 32'h1234_5000);
    check("lui_opcode", {25'b0, out_opcode}, 32'h37);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
